// File: rtl/level_mem_arbiter.sv
// level_mem_arbiter: shares the 8x3 user-level RAM between the game level
// controller (port A) and the admin/scoreboard scanner (port B).
// Each access runs IDLE -> ISSUE -> (WAIT) -> DONE. Written levels are clamped
// to MAX_LEVEL so the RAM never holds an illegal level.
// Optional macro LVL_ARB_RR_EN: round-robin arbitration on simultaneous
// requests. Without it, port A has fixed priority over port B.
module level_mem_arbiter #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 3,
  parameter int RD_LAT    = 2,
  parameter int MAX_LEVEL = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              done_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              done_b,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              clamp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [DATA_W-1:0] MAX_W  = DATA_W'(MAX_LEVEL);
  localparam logic [2:0]        LAT_M1 = 3'(RD_LAT - 1);

  logic [1:0]        state;
  logic              sel_l;      // 0 = port A, 1 = port B
  logic              we_l;
  logic              clamp_l;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        wait_cnt;

  logic              grant_b;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              g_over;
  logic [DATA_W-1:0] g_clamped;

`ifdef LVL_ARB_RR_EN
  logic rr_ptr;                  // 0 = favour A, 1 = favour B on a tie
`endif

  // Pick the port to serve next and clamp its write data before latching.
  always_comb begin
`ifdef LVL_ARB_RR_EN
    grant_b = req_b & (~req_a | rr_ptr);
`else
    grant_b = req_b & ~req_a;
`endif
    g_we      = grant_b ? we_b    : we_a;
    g_addr    = grant_b ? addr_b  : addr_a;
    g_wdata   = grant_b ? wdata_b : wdata_a;
    g_over    = (g_wdata > MAX_W);
    g_clamped = g_over ? MAX_W : g_wdata;
  end

  // Access sequencer: latch the request, drive the RAM, wait out the read
  // latency, then pulse completion for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      sel_l    <= 1'b0;
      we_l     <= 1'b0;
      clamp_l  <= 1'b0;
      addr_l   <= '0;
      wdata_l  <= '0;
      rdata_q  <= '0;
      wait_cnt <= 3'd0;
`ifdef LVL_ARB_RR_EN
      rr_ptr   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_a || req_b) begin
            sel_l   <= grant_b;
            we_l    <= g_we;
            addr_l  <= g_addr;
            wdata_l <= g_clamped;
            clamp_l <= g_over & g_we;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (we_l) begin
            state <= S_DONE;
          end else begin
            wait_cnt <= LAT_M1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) begin
            rdata_q <= mem_q;
            state   <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_DONE: begin
`ifdef LVL_ARB_RR_EN
          rr_ptr <= ~sel_l;
`endif
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign mem_wren    = (state == S_ISSUE) & we_l;
  assign clamp_err   = (state == S_ISSUE) & clamp_l;
  assign done_a      = (state == S_DONE) & ~sel_l;
  assign done_b      = (state == S_DONE) & sel_l;
  assign mem_address = addr_l;
  assign mem_data    = wdata_l;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_level_mem_arbiter.sv
// tb_level_mem_arbiter: directed self-checking bench for level_mem_arbiter.
// Includes a RAM model with a two-cycle registered read path.
module tb_level_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, we_a, req_b, we_b;
  logic [2:0] addr_a, wdata_a, addr_b, wdata_b;
  logic       done_a, done_b, busy, clamp_err, mem_wren;
  logic [2:0] rdata, mem_address, mem_data, mem_q;

  logic [2:0] ram [8];
  logic [2:0] q1, q2;
  logic       pre_en;
  logic [2:0] pre_addr, pre_data;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  level_mem_arbiter #(.ADDR_W(3), .DATA_W(3), .RD_LAT(2), .MAX_LEVEL(6)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .done_a(done_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .done_b(done_b),
    .rdata(rdata), .busy(busy), .clamp_err(clamp_err),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  // RAM model: synchronous write, read data appears two clocks after the address
  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_wren) ram[mem_address] <= mem_data;
    q1 <= ram[mem_address];
    q2 <= q1;
  end
  assign mem_q = q2;

  // Runs one transaction from an IDLE negedge and returns on the following IDLE negedge
  task automatic run_txn(input logic port_b, input logic we, input logic [2:0] addr,
                         input logic [2:0] wdata, output int lat, output logic [2:0] rd);
    if (port_b) begin req_b = 1; we_b = we; addr_b = addr; wdata_b = wdata; end
    else begin req_a = 1; we_a = we; addr_a = addr; wdata_a = wdata; end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ((port_b && done_b) || (!port_b && done_a)) begin lat = k; break; end
    end
    rd = rdata;
    req_a = 0; req_b = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
    pre_en = 1; pre_addr = 3; pre_data = 2;
    @(negedge clk);
    @(negedge clk);
    pre_en = 0;
    n_compared++;
    if ({busy, done_a, done_b, clamp_err, mem_wren, mem_address, mem_data, rdata} !== 14'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got %b expected 0",
               {busy, done_a, done_b, clamp_err, mem_wren, mem_address, mem_data, rdata});
    end
    rst = 0;
    @(negedge clk);
    n_compared++;
    if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL idle_after_reset busy: got %0d expected 0", busy); end
  endtask

  task automatic test_read();
    logic wren_seen = 0;
    req_a = 1; we_a = 0; addr_a = 3; wdata_a = 0;
    @(negedge clk);
    wren_seen |= mem_wren;
    n_compared++;
    if (mem_address !== 3'd3) begin n_mismatched++; $display("[TB] FAIL read_addr_n1: got %0d expected 3", mem_address); end
    n_compared++;
    if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL read_busy_n1: got %0d expected 1", busy); end
    @(negedge clk);
    wren_seen |= mem_wren;
    n_compared++;
    if (mem_address !== 3'd3) begin n_mismatched++; $display("[TB] FAIL read_addr_n2: got %0d expected 3", mem_address); end
    @(negedge clk);
    wren_seen |= mem_wren;
    n_compared++;
    if (done_a !== 1'b0) begin n_mismatched++; $display("[TB] FAIL read_early_done_n3: got %0d expected 0", done_a); end
    @(negedge clk);
    wren_seen |= mem_wren;
    n_compared++;
    if (done_a !== 1'b1) begin n_mismatched++; $display("[TB] FAIL read_done_n4: got %0d expected 1", done_a); end
    n_compared++;
    if (rdata !== 3'd2) begin n_mismatched++; $display("[TB] FAIL read_rdata: got %0d expected 2", rdata); end
    req_a = 0;
    n_compared++;
    if (wren_seen !== 1'b0) begin n_mismatched++; $display("[TB] FAIL read_wren_seen: got %0d expected 0", wren_seen); end
    @(negedge clk);
    n_compared++;
    if ({busy, done_a} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL read_back_idle: got %b expected 00", {busy, done_a}); end
    n_compared++;
    if (rdata !== 3'd2) begin n_mismatched++; $display("[TB] FAIL read_rdata_held: got %0d expected 2", rdata); end
  endtask

  task automatic test_write_clamp();
    int lat;
    logic [2:0] rd;
    req_b = 1; we_b = 1; addr_b = 5; wdata_b = 7;
    @(negedge clk);
    n_compared++;
    if (mem_wren !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wr_wren_n1: got %0d expected 1", mem_wren); end
    n_compared++;
    if (mem_data !== 3'd6) begin n_mismatched++; $display("[TB] FAIL wr_clamped_data: got %0d expected 6", mem_data); end
    n_compared++;
    if (mem_address !== 3'd5) begin n_mismatched++; $display("[TB] FAIL wr_addr: got %0d expected 5", mem_address); end
    n_compared++;
    if (clamp_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wr_clamp_err_n1: got %0d expected 1", clamp_err); end
    @(negedge clk);
    n_compared++;
    if (done_b !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wr_done_b_n2: got %0d expected 1", done_b); end
    n_compared++;
    if ({mem_wren, clamp_err} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL wr_pulses_n2: got %b expected 00", {mem_wren, clamp_err}); end
    n_compared++;
    if (ram[5] !== 3'd6) begin n_mismatched++; $display("[TB] FAIL wr_ram5: got %0d expected 6", ram[5]); end
    n_compared++;
    if (rdata !== 3'd2) begin n_mismatched++; $display("[TB] FAIL wr_rdata_untouched: got %0d expected 2", rdata); end
    req_b = 0;
    @(negedge clk);
    run_txn(1'b0, 1'b0, 3'd5, 3'd0, lat, rd);
    n_compared++;
    if (lat !== 4) begin n_mismatched++; $display("[TB] FAIL readback_latency: got %0d expected 4", lat); end
    n_compared++;
    if (rd !== 3'd6) begin n_mismatched++; $display("[TB] FAIL readback_data: got %0d expected 6", rd); end
    run_txn(1'b1, 1'b1, 3'd0, 3'd5, lat, rd);
    n_compared++;
    if (lat !== 2) begin n_mismatched++; $display("[TB] FAIL wr_addr0_latency: got %0d expected 2", lat); end
    n_compared++;
    if (ram[0] !== 3'd5) begin n_mismatched++; $display("[TB] FAIL wr_addr0_ram: got %0d expected 5", ram[0]); end
  endtask

  task automatic test_early_drop();
    req_a = 1; we_a = 1; addr_a = 1; wdata_a = 6;
    @(negedge clk);
    n_compared++;
    if ({mem_wren, clamp_err} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL drop_wren_noclamp: got %b expected 10", {mem_wren, clamp_err}); end
    n_compared++;
    if (mem_data !== 3'd6) begin n_mismatched++; $display("[TB] FAIL drop_data_max: got %0d expected 6", mem_data); end
    req_a = 0;
    @(negedge clk);
    n_compared++;
    if (done_a !== 1'b1) begin n_mismatched++; $display("[TB] FAIL drop_done_a: got %0d expected 1", done_a); end
    n_compared++;
    if (ram[1] !== 3'd6) begin n_mismatched++; $display("[TB] FAIL drop_ram1: got %0d expected 6", ram[1]); end
    @(negedge clk);
    n_compared++;
    if ({busy, done_a} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL drop_idle: got %b expected 00", {busy, done_a}); end
  endtask

  task automatic test_abort();
    int lat;
    logic [2:0] rd;
    logic done_seen = 0;
    req_a = 1; we_a = 0; addr_a = 3; wdata_a = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    n_compared++;
    if ({busy, mem_wren, mem_address} !== 5'd0) begin n_mismatched++; $display("[TB] FAIL abort_outputs: got %b expected 0", {busy, mem_wren, mem_address}); end
    n_compared++;
    if (rdata !== 3'd0) begin n_mismatched++; $display("[TB] FAIL abort_rdata: got %0d expected 0", rdata); end
    req_a = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      done_seen |= done_a | done_b;
      if (k == 1) rst = 0;
    end
    n_compared++;
    if (done_seen !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_no_done: got %0d expected 0", done_seen); end
    run_txn(1'b1, 1'b0, 3'd3, 3'd0, lat, rd);
    n_compared++;
    if (lat !== 4) begin n_mismatched++; $display("[TB] FAIL after_abort_latency: got %0d expected 4", lat); end
    n_compared++;
    if (rd !== 3'd2) begin n_mismatched++; $display("[TB] FAIL after_abort_data: got %0d expected 2", rd); end
  endtask

  task automatic test_contention();
    int cnt_a = 0;
    int cnt_b = 0;
    int nd = 0;
    logic [5:0] order = 6'd0;
    logic [5:0] exp_order;
    int exp_a;
    int exp_b;
`ifdef LVL_ARB_RR_EN
    exp_order = 6'b101010; exp_a = 3; exp_b = 3;
`else
    exp_order = 6'b000000; exp_a = 6; exp_b = 0;
`endif
    rst = 1;
    @(negedge clk);
    rst = 0;
    req_a = 1; we_a = 1; addr_a = 2; wdata_a = 3;
    req_b = 1; we_b = 1; addr_b = 4; wdata_b = 5;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (done_a) cnt_a++;
      if (done_b) cnt_b++;
      if ((done_a || done_b) && nd < 6) begin order[nd] = done_b; nd++; end
    end
    req_a = 0; req_b = 0;
    @(negedge clk);
    n_compared++;
    if (cnt_a !== exp_a) begin n_mismatched++; $display("[TB] FAIL contention_done_a_count: got %0d expected %0d", cnt_a, exp_a); end
    n_compared++;
    if (cnt_b !== exp_b) begin n_mismatched++; $display("[TB] FAIL contention_done_b_count: got %0d expected %0d", cnt_b, exp_b); end
    n_compared++;
    if (order !== exp_order) begin n_mismatched++; $display("[TB] FAIL contention_order: got %b expected %b", order, exp_order); end
    n_compared++;
    if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL contention_release_idle: got %0d expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_clamp();
    test_early_drop();
    test_abort();
    test_contention();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
